alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Issue/completion sequencer between the execute-stage decoder and the ALU (adder, logic, compare, iterative shifter, optional mul/div).
- Accepts one operation per valid/ready handshake and latches its operands and control. Holds the ALU enable for the whole operation and waits out the ALU busy flag.
- Registers the result and presents it downstream with a valid/ready handshake. Provides flush, a watchdog timeout and a pipeline stall.

Parameters:
- SETTLE_CYCLES, 1: cycles after issue during which i_alu_busy is ignored (busy rises one edge after enable); legal 0..7.
- TIMEOUT_CYCLES, 64: WAIT cycles before the watchdog fires; legal 2..1023.

Ports:
- i_clk_n  in  1  clock; all registers update on its falling edge
- i_rst  in  1  asynchronous reset, active-high
- i_flush  in  1  kill the in-flight or pending operation
- i_issue_valid  in  1  upstream operation valid
- o_issue_ready  out  1  controller accepts the operation this cycle
- i_in_a  in  32  operand A
- i_in_b  in  32  operand B / immediate
- i_funct3  in  3  ALU funct3
- i_funct7  in  7  ALU funct7
- i_alu_imm  in  1  immediate-form instruction
- i_rd  in  5  destination register tag
- o_alu_a  out  32  latched operand A to the ALU
- o_alu_b  out  32  latched operand B to the ALU
- o_alu_funct3  out  3  latched funct3
- o_alu_funct7  out  7  latched funct7
- o_alu_imm  out  1  latched imm flag
- o_alu_en  out  1  ALU enable
- i_alu_busy  in  1  ALU multi-cycle unit busy
- i_alu_out  in  32  ALU result (combinational)
- o_res_valid  out  1  result valid
- i_res_ready  in  1  downstream accepts the result
- o_res_data  out  32  registered result
- o_res_rd  out  5  registered destination tag
- o_stall  out  1  execute stage must hold
- o_timeout  out  1  sticky watchdog error flag

Behaviour:
- States: IDLE, SETTLE, WAIT, DONE, plus a one-cycle FLUSHED state.
- Reset (asynchronous): state = IDLE. All data/control outputs are 0: o_alu_en, o_res_valid, o_timeout, o_res_data, o_res_rd and the latched operand regs. Counters are 0.
- Issue accept:
  - Accept = i_issue_valid && o_issue_ready.
  - o_issue_ready = !i_flush && (state==IDLE || (state==DONE && i_res_ready)).
  - On accept: latch a, b, funct3, funct7, imm, rd and set o_alu_en=1.
  - Next state is SETTLE with settle counter = SETTLE_CYCLES-1, or WAIT directly when SETTLE_CYCLES=0.
- SETTLE: i_alu_busy is ignored; decrement the counter; at 0, go to WAIT.
- WAIT:
  - Watchdog counter increments each cycle.
  - On i_alu_busy=0: o_res_data <= i_alu_out, o_res_rd <= latched rd, o_alu_en <= 0, go to DONE.
  - If the watchdog reaches TIMEOUT_CYCLES with busy still high: set o_timeout (sticky until reset), capture i_alu_out anyway, go to DONE.
- DONE:
  - o_res_valid=1.
  - o_res_data/o_res_rd hold stable until the handshake (i_res_ready high).
  - On handshake with a simultaneous accept: go to SETTLE with new operands (back-to-back).
  - On handshake without an accept: go to IDLE.
- The latched operands drive the ALU from accept until capture; o_alu_en stays continuously high over that window.
- Latency, single-cycle op, SETTLE_CYCLES=1: accept at edge N, o_res_valid high after edge N+2.
- Latency, k-cycle busy: o_res_valid high one edge after the first busy-low cycle in WAIT.
- o_stall = i_issue_valid && !o_issue_ready.
- Flush:
  - Highest priority, in any state.
  - Next edge: o_alu_en=0, o_res_valid=0, counters cleared, state = FLUSHED.
  - FLUSHED holds o_issue_ready=0 for one cycle so the iterative units see enable low, then goes to IDLE.
  - An issue presented in the same cycle as i_flush is not accepted.
  - o_timeout is unaffected by flush.
- Watchdog and settle counters are never observed across operations; both are reloaded on every accept.

Test Plan:
- ADD: SETTLE_CYCLES=1, a=5, b=7, funct3=000, busy stays 0 -> o_res_valid high 2 edges after accept, o_res_data=12, o_res_rd=issued rd, o_alu_en low in DONE.
- Shift with busy high for 5 cycles after SETTLE -> o_res_valid rises exactly one edge after busy falls; o_alu_en high with constant operands throughout; o_stall high for a second issue_valid.
- Back-to-back: DONE with i_res_ready=1 and i_issue_valid=1 (a=1, b=2, funct3=110) -> no IDLE cycle, next result 3 after 2 more edges.
- Backpressure: i_res_ready=0 for 4 cycles in DONE -> o_res_data constant, o_issue_ready=0, o_stall follows i_issue_valid.
- Flush mid-WAIT with busy high -> next edge o_alu_en=0 and o_res_valid=0; one cycle o_issue_ready=0; then a new issue is accepted normally. Repeat with flush and issue in the same cycle -> the issue is not accepted.
- Watchdog: TIMEOUT_CYCLES=8, busy stuck high -> o_timeout set after 8 WAIT cycles, DONE entered. i_rst mid-WAIT -> all outputs 0 immediately (asynchronous), o_timeout cleared.

Source files
------------

// File: rtl/alu_seq_ctrl_if.sv
// Bundle of issue, ALU-side and result-side signals between the execute-stage
// decoder, the ALU and the sequencer. The slave modport is the sequencer's view.
interface alu_seq_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              i_flush;
  logic              i_issue_valid;
  logic              o_issue_ready;
  logic [DATA_W-1:0] i_in_a;
  logic [DATA_W-1:0] i_in_b;
  logic [2:0]        i_funct3;
  logic [6:0]        i_funct7;
  logic              i_alu_imm;
  logic [4:0]        i_rd;
  logic [DATA_W-1:0] o_alu_a;
  logic [DATA_W-1:0] o_alu_b;
  logic [2:0]        o_alu_funct3;
  logic [6:0]        o_alu_funct7;
  logic              o_alu_imm;
  logic              o_alu_en;
  logic              i_alu_busy;
  logic [DATA_W-1:0] i_alu_out;
  logic              o_res_valid;
  logic              i_res_ready;
  logic [DATA_W-1:0] o_res_data;
  logic [4:0]        o_res_rd;
  logic              o_stall;
  logic              o_timeout;

  modport slave (
    input  i_flush, i_issue_valid, i_in_a, i_in_b, i_funct3, i_funct7, i_alu_imm, i_rd,
    input  i_alu_busy, i_alu_out, i_res_ready,
    output o_issue_ready, o_alu_a, o_alu_b, o_alu_funct3, o_alu_funct7, o_alu_imm, o_alu_en,
    output o_res_valid, o_res_data, o_res_rd, o_stall, o_timeout
  );

  modport master (
    output i_flush, i_issue_valid, i_in_a, i_in_b, i_funct3, i_funct7, i_alu_imm, i_rd,
    output i_alu_busy, i_alu_out, i_res_ready,
    input  o_issue_ready, o_alu_a, o_alu_b, o_alu_funct3, o_alu_funct7, o_alu_imm, o_alu_en,
    input  o_res_valid, o_res_data, o_res_rd, o_stall, o_timeout
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Issue/completion sequencer for the ALU: latches one operation, holds the ALU
// enable while waiting out busy, and hands the registered result downstream.
module alu_seq_ctrl #(
  parameter int DATA_W         = 32,
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic           i_clk_n,
  input logic           i_rst,
  alu_seq_ctrl_if.slave bus
);

  localparam int              WD_W        = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST     = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      SETTLE_INIT = 3'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, WAIT, DONE, FLUSHED} state_e;

  state_e            state_q, state_d;
  logic [2:0]        settle_q, settle_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_data_q, res_data_d;
  logic [2:0]        f3_q, f3_d;
  logic [6:0]        f7_q, f7_d;
  logic              imm_q, imm_d;
  logic [4:0]        rd_q, rd_d, res_rd_q, res_rd_d;
  logic              alu_en_q, alu_en_d, res_valid_q, res_valid_d, timeout_q, timeout_d;
  logic              issue_ready, accept;

  assign issue_ready = !bus.i_flush && (state_q == IDLE || (state_q == DONE && bus.i_res_ready));
  assign accept      = bus.i_issue_valid && issue_ready;

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    wdog_d      = wdog_q;
    a_d         = a_q;
    b_d         = b_q;
    f3_d        = f3_q;
    f7_d        = f7_q;
    imm_d       = imm_q;
    rd_d        = rd_q;
    alu_en_d    = alu_en_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_rd_d    = res_rd_q;
    timeout_d   = timeout_q;
    if (bus.i_flush) begin
      state_d     = FLUSHED;
      alu_en_d    = 1'b0;
      res_valid_d = 1'b0;
      settle_d    = '0;
      wdog_d      = '0;
    end else begin
      case (state_q)
        IDLE: ;
        SETTLE: begin
          if (settle_q == '0) state_d = WAIT;
          else                settle_d = settle_q - 1'b1;
        end
        WAIT: begin
          // A stuck busy still completes the op, with the error flagged.
          if (!bus.i_alu_busy || wdog_q == WD_LAST) begin
            res_data_d  = bus.i_alu_out;
            res_rd_d    = rd_q;
            alu_en_d    = 1'b0;
            res_valid_d = 1'b1;
            state_d     = DONE;
            if (bus.i_alu_busy) timeout_d = 1'b1;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.i_res_ready) begin
            res_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        FLUSHED: state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (accept) begin
        a_d         = bus.i_in_a;
        b_d         = bus.i_in_b;
        f3_d        = bus.i_funct3;
        f7_d        = bus.i_funct7;
        imm_d       = bus.i_alu_imm;
        rd_d        = bus.i_rd;
        alu_en_d    = 1'b1;
        res_valid_d = 1'b0;
        settle_d    = SETTLE_INIT;
        wdog_d      = '0;
        state_d     = (SETTLE_CYCLES == 0) ? WAIT : SETTLE;
      end
    end
  end

  always_ff @(negedge i_clk_n or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      wdog_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      f3_q        <= '0;
      f7_q        <= '0;
      imm_q       <= 1'b0;
      rd_q        <= '0;
      alu_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      wdog_q      <= wdog_d;
      a_q         <= a_d;
      b_q         <= b_d;
      f3_q        <= f3_d;
      f7_q        <= f7_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      alu_en_q    <= alu_en_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.o_issue_ready = issue_ready;
  assign bus.o_stall       = bus.i_issue_valid && !issue_ready;
  assign bus.o_alu_a       = a_q;
  assign bus.o_alu_b       = b_q;
  assign bus.o_alu_funct3  = f3_q;
  assign bus.o_alu_funct7  = f7_q;
  assign bus.o_alu_imm     = imm_q;
  assign bus.o_alu_en      = alu_en_q;
  assign bus.o_res_valid   = res_valid_q;
  assign bus.o_res_data    = res_data_q;
  assign bus.o_res_rd      = res_rd_q;
  assign bus.o_timeout     = timeout_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed and randomized operations scored against a
// latency/result model derived from the operation's busy length.
module tb_alu_seq_ctrl;
  localparam int SETTLE = 1;
  localparam int TMO    = 8;

  logic clk = 1'b1;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  bit          pending = 1'b0;
  logic [31:0] exp_data;
  logic [4:0]  exp_rd;
  bit          exp_to = 1'b0;

  alu_seq_ctrl_if #(.DATA_W(32)) bus ();

  alu_seq_ctrl #(
    .DATA_W(32),
    .SETTLE_CYCLES(SETTLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk_n(clk),
    .i_rst  (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // ALU stand-in: result is inverted while busy, so a premature capture shows.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f3, input logic [6:0] f7,
                                         input logic imm);
    logic [31:0] r;
    case (f3)
      3'b000:  r = (f7[5] && !imm) ? a - b : a + b;
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'd0, $signed(a) < $signed(b)};
      3'b011:  r = {31'd0, a < b};
      3'b100:  r = a ^ b;
      3'b101:  r = f7[5] ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  assign bus.i_alu_out = bus.i_alu_busy
      ? ~alu_fn(bus.o_alu_a, bus.o_alu_b, bus.o_alu_funct3, bus.o_alu_funct7, bus.o_alu_imm)
      :  alu_fn(bus.o_alu_a, bus.o_alu_b, bus.o_alu_funct3, bus.o_alu_funct7, bus.o_alu_imm);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation from issue to a pending result; busy held k WAIT cycles,
  // then r extra DONE cycles of backpressure.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                       input logic [6:0] f7, input logic imm, input logic [4:0] rd,
                       input int k, input int r);
    int          lat;
    logic [31:0] res;
    res = alu_fn(a, b, f3, f7, imm);
    if (k >= TMO) begin
      lat    = SETTLE + TMO;
      res    = ~res;
      exp_to = 1'b1;
    end else begin
      lat = SETTLE + k + 1;
    end
    bus.i_issue_valid = 1'b1;
    bus.i_in_a = a;  bus.i_in_b = b;  bus.i_funct3 = f3;
    bus.i_funct7 = f7;  bus.i_alu_imm = imm;  bus.i_rd = rd;
    bus.i_res_ready = 1'b1;
    bus.i_alu_busy  = 1'b0;
    bus.i_flush     = 1'b0;
    #1;
    chk("accept_ready", bus.o_issue_ready, 1);
    chk("accept_stall", bus.o_stall, 0);
    chk("accept_prev_valid", bus.o_res_valid, pending);
    @(posedge clk);
    bus.i_res_ready = 1'b0;
    bus.i_in_a = $urandom();
    bus.i_in_b = $urandom();
    for (int m = 0; m <= lat; m++) begin
      bus.i_alu_busy    = (m < lat) && (m < SETTLE + k);
      bus.i_issue_valid = (m == 1);
      #1;
      if (m < lat) begin
        chk("op_alu_en", bus.o_alu_en, 1);
        chk("op_alu_a", bus.o_alu_a, a);
        chk("op_alu_b", bus.o_alu_b, b);
        chk("op_ready", bus.o_issue_ready, 0);
        chk("op_stall", bus.o_stall, (m == 1));
        chk("op_res_valid", bus.o_res_valid, 0);
        if (m == 0) chk("op_ctl", {bus.o_alu_imm, bus.o_alu_funct7, bus.o_alu_funct3}, {imm, f7, f3});
        @(posedge clk);
      end else begin
        chk("done_valid", bus.o_res_valid, 1);
        chk("done_alu_en", bus.o_alu_en, 0);
        chk("done_data", bus.o_res_data, res);
        chk("done_rd", bus.o_res_rd, rd);
        chk("done_timeout", bus.o_timeout, exp_to);
      end
    end
    for (int j = 0; j < r; j++) begin
      @(posedge clk);
      bus.i_issue_valid = 1'($urandom_range(0, 1));
      #1;
      chk("bp_valid", bus.o_res_valid, 1);
      chk("bp_data", bus.o_res_data, res);
      chk("bp_ready", bus.o_issue_ready, 0);
      chk("bp_stall", bus.o_stall, bus.i_issue_valid);
    end
    @(posedge clk);
    bus.i_issue_valid = 1'b0;
    pending  = 1'b1;
    exp_data = res;
    exp_rd   = rd;
  endtask

  task automatic drain();
    bus.i_res_ready   = 1'b1;
    bus.i_issue_valid = 1'b0;
    #1;
    chk("drain_valid", bus.o_res_valid, 1);
    chk("drain_data", bus.o_res_data, exp_data);
    chk("drain_ready", bus.o_issue_ready, 1);
    @(posedge clk);
    bus.i_res_ready = 1'b0;
    #1;
    chk("idle_valid", bus.o_res_valid, 0);
    chk("idle_ready", bus.o_issue_ready, 1);
    chk("idle_alu_en", bus.o_alu_en, 0);
    pending = 1'b0;
  endtask

  // Start an op with busy stuck high, then kill it mid-WAIT by flush or reset.
  task automatic abort_op(input bit use_rst);
    bus.i_issue_valid = 1'b1;
    bus.i_in_a = $urandom();  bus.i_in_b = $urandom();
    bus.i_funct3 = 3'b000;  bus.i_rd = 5'd21;
    bus.i_res_ready = 1'b0;
    #1;
    chk("abort_accept", bus.o_issue_ready, 1);
    @(posedge clk);
    bus.i_issue_valid = 1'b0;
    bus.i_alu_busy    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_wait_en", bus.o_alu_en, 1);
    if (!use_rst) begin
      bus.i_flush = 1'b1;
      #1;
      chk("flush_ready", bus.o_issue_ready, 0);
      @(posedge clk);
      bus.i_flush       = 1'b0;
      bus.i_alu_busy    = 1'b0;
      bus.i_issue_valid = 1'b1;
      #1;
      chk("flushed_alu_en", bus.o_alu_en, 0);
      chk("flushed_valid", bus.o_res_valid, 0);
      chk("flushed_ready", bus.o_issue_ready, 0);
      chk("flushed_stall", bus.o_stall, 1);
      chk("flushed_timeout", bus.o_timeout, exp_to);
      @(posedge clk);
      bus.i_issue_valid = 1'b0;
      #1;
      chk("post_flush_ready", bus.o_issue_ready, 1);
      chk("post_flush_en", bus.o_alu_en, 0);
    end else begin
      #2 rst = 1'b1;
      #1;
      chk("arst_alu_en", bus.o_alu_en, 0);
      chk("arst_valid", bus.o_res_valid, 0);
      chk("arst_timeout", bus.o_timeout, 0);
      chk("arst_data", bus.o_res_data, 0);
      chk("arst_rd", bus.o_res_rd, 0);
      chk("arst_alu_a", bus.o_alu_a, 0);
      chk("arst_alu_b", bus.o_alu_b, 0);
      exp_to  = 1'b0;
      pending = 1'b0;
      @(posedge clk);
      rst = 1'b0;
      bus.i_alu_busy = 1'b0;
      #1;
      chk("post_rst_ready", bus.o_issue_ready, 1);
    end
  endtask

  task automatic flush_with_issue();
    bus.i_flush       = 1'b1;
    bus.i_issue_valid = 1'b1;
    bus.i_in_a        = 32'h1234_5678;
    #1;
    chk("fi_ready", bus.o_issue_ready, 0);
    chk("fi_stall", bus.o_stall, 1);
    @(posedge clk);
    bus.i_flush       = 1'b0;
    bus.i_issue_valid = 1'b0;
    #1;
    chk("fi_hold_ready", bus.o_issue_ready, 0);
    chk("fi_hold_en", bus.o_alu_en, 0);
    @(posedge clk);
    #1;
    chk("fi_idle_ready", bus.o_issue_ready, 1);
    chk("fi_idle_en", bus.o_alu_en, 0);
    chk("fi_idle_valid", bus.o_res_valid, 0);
  endtask

  initial begin
    int k;
    int r;
    rst = 1'b1;
    bus.i_flush = 1'b0;  bus.i_issue_valid = 1'b0;
    bus.i_in_a = '0;  bus.i_in_b = '0;  bus.i_funct3 = '0;  bus.i_funct7 = '0;
    bus.i_alu_imm = 1'b0;  bus.i_rd = '0;  bus.i_alu_busy = 1'b0;  bus.i_res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_en", bus.o_alu_en, 0);
    chk("rst_valid", bus.o_res_valid, 0);
    chk("rst_timeout", bus.o_timeout, 0);
    chk("rst_data", bus.o_res_data, 0);
    chk("rst_rd", bus.o_res_rd, 0);
    chk("rst_alu_a", bus.o_alu_a, 0);
    chk("rst_ctl", {bus.o_alu_imm, bus.o_alu_funct7, bus.o_alu_funct3}, 0);
    chk("rst_ready", bus.o_issue_ready, 1);
    @(posedge clk);
    rst = 1'b0;

    do_op(32'd5, 32'd7, 3'b000, 7'd0, 1'b0, 5'd9, 0, 0);
    drain();
    do_op(32'h0000_00F0, 32'd4, 3'b001, 7'd0, 1'b1, 5'd3, 5, 0);
    do_op(32'd1, 32'd2, 3'b110, 7'd0, 1'b0, 5'd17, 0, 4);
    drain();
    do_op(32'hFFFF_FF00, 32'd4, 3'b101, 7'h20, 1'b1, 5'd30, TMO - 1, 1);
    drain();
    abort_op(1'b0);
    do_op(32'd100, 32'd58, 3'b000, 7'h20, 1'b0, 5'd4, 2, 1);
    drain();
    flush_with_issue();

    repeat (40) begin
      k = $urandom_range(0, TMO - 1);
      r = $urandom_range(0, 3);
      do_op($urandom(), $urandom(), 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), k, r);
      if ($urandom_range(0, 2) == 0) drain();
    end
    if (pending) drain();

    do_op(32'hDEAD_0000, 32'h0000_BEEF, 3'b100, 7'd0, 1'b0, 5'd12, TMO + 4, 1);
    drain();
    abort_op(1'b0);
    do_op(32'd9, 32'd3, 3'b111, 7'd0, 1'b0, 5'd7, 1, 0);
    drain();
    abort_op(1'b1);
    do_op(32'd40, 32'd2, 3'b000, 7'd0, 1'b1, 5'd1, 0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
